pattern_stream_gen: RTL and testbench

Serial bit-stream transmitter that drives the `d`/`valid` interface consumed by the Mealy pattern detector. On a start request it emits a programmable W-bit pattern MSB-first, a programmable number of times, with filler bits inserted before each copy. It gives the detector bench a deterministic, countable source of pattern occurrences. Supports ready backpressure, and reports how many copies it has fully sent.

---
 rtl/pattern_stream_gen_if.sv | 25 ++
 rtl/pattern_stream_gen.sv | 179 +++++++++++++++++
 tb/tb_pattern_stream_gen.sv | 331 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pattern_stream_gen_if.sv
// Handshake bundle between the pattern stream generator and its sink/controller.
interface pattern_stream_gen_if #(
    parameter int W = 4
);
    logic         start_i;
    logic [W-1:0] pattern_i;
    logic [7:0]   repeat_i;
    logic [3:0]   gap_i;
    logic         ready_i;
    logic         d_o;
    logic         valid_o;
    logic         busy_o;
    logic         done_o;
    logic [7:0]   sent_cnt_o;

    modport master (
        input  start_i, pattern_i, repeat_i, gap_i, ready_i,
        output d_o, valid_o, busy_o, done_o, sent_cnt_o
    );

    modport slave (
        output start_i, pattern_i, repeat_i, gap_i, ready_i,
        input  d_o, valid_o, busy_o, done_o, sent_cnt_o
    );
endinterface

// File: rtl/pattern_stream_gen.sv
// Serial pattern transmitter: gap filler + W-bit pattern, repeated, MSB-first.
// PATTERN_GEN_LFSR_FILL_EN selects LFSR filler bits instead of constant 0.
module pattern_stream_gen #(
    parameter int         W         = 4,
    parameter logic [7:0] LFSR_SEED = 8'hA5
) (
    input logic clk,
    input logic rst,
    pattern_stream_gen_if.master bus
);
    localparam int IW = $clog2(W);
    localparam logic [IW-1:0] TOP = IW'(W - 1);

    typedef enum logic [1:0] {IDLE, GAP, SEND, DONE} state_t;

    state_t        state_q, state_d;
    logic [W-1:0]  pat_q, pat_d;
    logic [7:0]    rep_q, rep_d;
    logic [3:0]    gap_q, gap_d;
    logic [3:0]    gcnt_q, gcnt_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [IW-1:0] idx_m1;
    logic [7:0]    cnt_q, cnt_d;
    logic          d_q, d_d;
    logic          valid_q, valid_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          xfer;
    logic          accept;
    logic          fill_cur, fill_nxt, fill_seed;

    assign xfer   = valid_q & bus.ready_i;
    assign accept = (state_q == IDLE) & bus.start_i;
    assign idx_m1 = idx_q - 1'b1;

`ifdef PATTERN_GEN_LFSR_FILL_EN
    logic [7:0] lfsr_q, lfsr_d, lfsr_nx;

    // x^8+x^6+x^5+x^4+1, filler bit taken from the LSB
    assign lfsr_nx = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

    always_comb begin
        lfsr_d = lfsr_q;
        if (accept)
            lfsr_d = LFSR_SEED;
        else if (state_q == GAP && xfer)
            lfsr_d = lfsr_nx;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) lfsr_q <= LFSR_SEED;
        else     lfsr_q <= lfsr_d;
    end

    assign fill_cur  = lfsr_q[0];
    assign fill_nxt  = lfsr_nx[0];
    assign fill_seed = LFSR_SEED[0];
`else
    assign fill_cur  = 1'b0;
    assign fill_nxt  = 1'b0;
    assign fill_seed = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        rep_d   = rep_q;
        gap_d   = gap_q;
        gcnt_d  = gcnt_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        d_d     = d_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start_i) begin
                    pat_d  = bus.pattern_i;
                    rep_d  = bus.repeat_i;
                    gap_d  = bus.gap_i;
                    cnt_d  = 8'd0;
                    busy_d = 1'b1;
                    if (bus.repeat_i == 8'd0) begin
                        state_d = DONE;
                        valid_d = 1'b0;
                        d_d     = 1'b0;
                        done_d  = 1'b1;
                    end else if (bus.gap_i == 4'd0) begin
                        state_d = SEND;
                        idx_d   = TOP;
                        d_d     = bus.pattern_i[W-1];
                        valid_d = 1'b1;
                    end else begin
                        state_d = GAP;
                        gcnt_d  = bus.gap_i - 4'd1;
                        d_d     = fill_seed;
                        valid_d = 1'b1;
                    end
                end
            end
            GAP: begin
                if (xfer) begin
                    if (gcnt_q == 4'd0) begin
                        state_d = SEND;
                        idx_d   = TOP;
                        d_d     = pat_q[W-1];
                    end else begin
                        gcnt_d = gcnt_q - 4'd1;
                        d_d    = fill_nxt;
                    end
                end
            end
            SEND: begin
                if (xfer) begin
                    if (idx_q == '0) begin
                        cnt_d = cnt_q + 8'd1;
                        if (cnt_q == rep_q - 8'd1) begin
                            state_d = DONE;
                            valid_d = 1'b0;
                            d_d     = 1'b0;
                            done_d  = 1'b1;
                        end else if (gap_q == 4'd0) begin
                            idx_d = TOP;
                            d_d   = pat_q[W-1];
                        end else begin
                            state_d = GAP;
                            gcnt_d  = gap_q - 4'd1;
                            // LFSR already advanced past the last filler sent
                            d_d     = fill_cur;
                        end
                    end else begin
                        idx_d = idx_m1;
                        d_d   = pat_q[idx_m1];
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                valid_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            pat_q   <= '0;
            rep_q   <= 8'd0;
            gap_q   <= 4'd0;
            gcnt_q  <= 4'd0;
            idx_q   <= '0;
            cnt_q   <= 8'd0;
            d_q     <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            rep_q   <= rep_d;
            gap_q   <= gap_d;
            gcnt_q  <= gcnt_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            d_q     <= d_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.d_o        = d_q;
    assign bus.valid_o    = valid_q;
    assign bus.busy_o     = busy_q;
    assign bus.done_o     = done_q;
    assign bus.sent_cnt_o = cnt_q;
endmodule

// File: tb/tb_pattern_stream_gen.sv
// Directed bench for pattern_stream_gen (W=4, seed 8'hA5).
module tb_pattern_stream_gen;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pattern_stream_gen_if #(.W(4)) bus ();

    pattern_stream_gen #(.W(4), .LFSR_SEED(8'hA5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_run  = 0;
    int n_fail = 0;

    bit   cap_q[$];
    bit   exp_q[$];
    int   done_cyc;
    int   cnt_at_done;
    bit   valid_at_done;
    bit   hold_bad;
    bit   bubble;

    function automatic logic [7:0] lstep(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

    function automatic int qdiff();
        if (cap_q.size() != exp_q.size()) return -2;
        foreach (cap_q[i]) if (cap_q[i] !== exp_q[i]) return i;
        return -1;
    endfunction

    task automatic build_exp(input logic [3:0] pat, input int rep, input int gap);
        logic [7:0] s;
        s = 8'hA5;
        exp_q.delete();
        for (int r = 0; r < rep; r++) begin
            for (int g = 0; g < gap; g++) begin
`ifdef PATTERN_GEN_LFSR_FILL_EN
                exp_q.push_back(s[0]);
                s = lstep(s);
`else
                exp_q.push_back(1'b0);
`endif
            end
            for (int b = 3; b >= 0; b--) exp_q.push_back(pat[b]);
        end
    endtask

    task automatic run(input logic [3:0] pat, input logic [7:0] rep,
                       input logic [3:0] gap, input int stall_at,
                       input int stall_len);
        int  rem;
        bit  stalled;
        logic sd;
        cap_q.delete();
        done_cyc = -1;
        cnt_at_done = -1;
        valid_at_done = 1'b1;
        hold_bad = 1'b0;
        bubble = 1'b0;
        stalled = 1'b0;
        sd = 1'b0;
        rem = stall_len;
        @(negedge clk);
        bus.pattern_i = pat;
        bus.repeat_i  = rep;
        bus.gap_i     = gap;
        bus.ready_i   = 1'b1;
        bus.start_i   = 1'b1;
        @(negedge clk);
        bus.start_i   = 1'b0;
        bus.pattern_i = ~pat;
        bus.repeat_i  = rep + 8'd5;
        bus.gap_i     = gap + 4'd1;
        for (int cyc = 1; cyc <= 400; cyc++) begin
            if (bus.done_o) begin
                done_cyc      = cyc;
                cnt_at_done   = bus.sent_cnt_o;
                valid_at_done = bus.valid_o;
                break;
            end
            if (!bus.valid_o) bubble = 1'b1;
            if (rem > 0 && cap_q.size() == stall_at) begin
                if (!stalled) begin
                    sd = bus.d_o;
                    stalled = 1'b1;
                end else if (bus.d_o !== sd || bus.valid_o !== 1'b1) begin
                    hold_bad = 1'b1;
                end
                bus.ready_i = 1'b0;
                rem--;
            end else begin
                if (stalled && cap_q.size() == stall_at && bus.d_o !== sd)
                    hold_bad = 1'b1;
                bus.ready_i = 1'b1;
                if (bus.valid_o) cap_q.push_back(bus.d_o);
            end
            @(negedge clk);
        end
        bus.ready_i = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start_i = 1'b0;
        bus.pattern_i = 4'd0;
        bus.repeat_i = 8'd0;
        bus.gap_i = 4'd0;
        bus.ready_i = 1'b1;
        repeat (2) @(negedge clk);
        n_run++;
        if (bus.d_o !== 1'b0) begin
            n_fail++; $display("FAIL reset_d: got %b required 0", bus.d_o);
        end
        n_run++;
        if (bus.valid_o !== 1'b0) begin
            n_fail++; $display("FAIL reset_valid: got %b required 0", bus.valid_o);
        end
        n_run++;
        if (bus.busy_o !== 1'b0) begin
            n_fail++; $display("FAIL reset_busy: got %b required 0", bus.busy_o);
        end
        n_run++;
        if (bus.done_o !== 1'b0) begin
            n_fail++; $display("FAIL reset_done: got %b required 0", bus.done_o);
        end
        n_run++;
        if (bus.sent_cnt_o !== 8'd0) begin
            n_fail++; $display("FAIL reset_cnt: got %0d required 0", bus.sent_cnt_o);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int k;
        build_exp(4'b1011, 3, 2);
        run(4'b1011, 8'd3, 4'd2, -1, 0);
        k = qdiff();
        n_run++;
        if (k != -1) begin
            n_fail++; $display("FAIL basic_stream: got %0d bits diff@%0d required 18 bits equal", cap_q.size(), k);
        end
        n_run++;
        if (done_cyc != 19) begin
            n_fail++; $display("FAIL basic_done_cyc: got %0d required 19", done_cyc);
        end
        n_run++;
        if (cnt_at_done != 3) begin
            n_fail++; $display("FAIL basic_sent_cnt: got %0d required 3", cnt_at_done);
        end
        n_run++;
        if (bubble !== 1'b0) begin
            n_fail++; $display("FAIL basic_bubble: got %b required 0", bubble);
        end
        n_run++;
        if (bus.busy_o !== 1'b1) begin
            n_fail++; $display("FAIL basic_busy_done: got %b required 1", bus.busy_o);
        end
        @(negedge clk);
        n_run++;
        if (bus.done_o !== 1'b0 || bus.busy_o !== 1'b0) begin
            n_fail++; $display("FAIL basic_after_done: got done=%b busy=%b required 0 0", bus.done_o, bus.busy_o);
        end
    endtask

    task automatic test_gap0();
        int k;
        int hits;
        logic [3:0] sh;
        build_exp(4'b1101, 2, 0);
        run(4'b1101, 8'd2, 4'd0, -1, 0);
        k = qdiff();
        n_run++;
        if (k != -1) begin
            n_fail++; $display("FAIL gap0_stream: got %0d bits diff@%0d required 11011101", cap_q.size(), k);
        end
        n_run++;
        if (done_cyc != 9 || bubble !== 1'b0) begin
            n_fail++; $display("FAIL gap0_timing: got done_cyc=%0d bubble=%b required 9 0", done_cyc, bubble);
        end
        hits = 0;
        sh = 4'd0;
        foreach (cap_q[i]) begin
            sh = {sh[2:0], cap_q[i]};
            if (i >= 3 && sh == 4'b1101) hits++;
        end
        n_run++;
        if (hits != 2) begin
            n_fail++; $display("FAIL gap0_detect: got %0d required 2", hits);
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        int k;
        build_exp(4'b1011, 3, 2);
        run(4'b1011, 8'd3, 4'd2, 3, 3);
        k = qdiff();
        n_run++;
        if (k != -1) begin
            n_fail++; $display("FAIL bp_stream: got %0d bits diff@%0d required 18 bits equal", cap_q.size(), k);
        end
        n_run++;
        if (hold_bad !== 1'b0) begin
            n_fail++; $display("FAIL bp_hold: got unstable=%b required 0", hold_bad);
        end
        n_run++;
        if (done_cyc != 22) begin
            n_fail++; $display("FAIL bp_done_cyc: got %0d required 22", done_cyc);
        end
        @(negedge clk);
    endtask

    task automatic test_repeat0();
        run(4'b1011, 8'd0, 4'd2, -1, 0);
        n_run++;
        if (done_cyc != 1) begin
            n_fail++; $display("FAIL rep0_done_cyc: got %0d required 1", done_cyc);
        end
        n_run++;
        if (valid_at_done !== 1'b0 || cap_q.size() != 0) begin
            n_fail++; $display("FAIL rep0_valid: got valid=%b bits=%0d required 0 0", valid_at_done, cap_q.size());
        end
        n_run++;
        if (cnt_at_done != 0) begin
            n_fail++; $display("FAIL rep0_cnt: got %0d required 0", cnt_at_done);
        end
        @(negedge clk);
        n_run++;
        if (bus.done_o !== 1'b0 || bus.valid_o !== 1'b0) begin
            n_fail++; $display("FAIL rep0_after: got done=%b valid=%b required 0 0", bus.done_o, bus.valid_o);
        end
    endtask

    task automatic test_midrun_reset();
        int xfers;
        int k;
        bit hit;
        xfers = 0;
        hit = 1'b0;
        @(negedge clk);
        bus.pattern_i = 4'b1011;
        bus.repeat_i  = 8'd3;
        bus.gap_i     = 4'd2;
        bus.ready_i   = 1'b1;
        bus.start_i   = 1'b1;
        @(negedge clk);
        bus.start_i = 1'b0;
        for (int cyc = 0; cyc < 50; cyc++) begin
            if (bus.valid_o && xfers == 4) begin
                hit = 1'b1;
                break;
            end
            if (bus.valid_o) xfers++;
            @(negedge clk);
        end
        n_run++;
        if (!hit) begin
            n_fail++; $display("FAIL mrst_reach: got %0d transfers required 5th reached", xfers);
        end
        rst = 1'b1;
        #1;
        n_run++;
        if ({bus.d_o, bus.valid_o, bus.busy_o, bus.done_o} !== 4'b0000 ||
            bus.sent_cnt_o !== 8'd0) begin
            n_fail++; $display("FAIL mrst_clear: got d/v/b/dn=%b%b%b%b cnt=%0d required 0000 0",
                bus.d_o, bus.valid_o, bus.busy_o, bus.done_o, bus.sent_cnt_o);
        end
        @(negedge clk);
        n_run++;
        if (bus.done_o !== 1'b0) begin
            n_fail++; $display("FAIL mrst_no_done: got %b required 0", bus.done_o);
        end
        rst = 1'b0;
        build_exp(4'b1011, 3, 2);
        run(4'b1011, 8'd3, 4'd2, -1, 0);
        k = qdiff();
        n_run++;
        if (k != -1 || done_cyc != 19) begin
            n_fail++; $display("FAIL mrst_rerun: got diff@%0d done_cyc=%0d required -1 19", k, done_cyc);
        end
        @(negedge clk);
    endtask

    task automatic test_lfsr_fill();
        int k;
        logic [7:0] fill_exp;
        logic [7:0] fill_got;
`ifdef PATTERN_GEN_LFSR_FILL_EN
        fill_exp = 8'b1010_0111;
`else
        fill_exp = 8'b0000_0000;
`endif
        build_exp(4'b1011, 1, 8);
        run(4'b1011, 8'd1, 4'd8, -1, 0);
        fill_got = 8'd0;
        for (int i = 0; i < 8 && i < cap_q.size(); i++)
            fill_got[7-i] = cap_q[i];
        n_run++;
        if (fill_got !== fill_exp || cap_q.size() != 12) begin
            n_fail++; $display("FAIL fill_bits: got %b (%0d bits) required %b (12 bits)", fill_got, cap_q.size(), fill_exp);
        end
        k = qdiff();
        n_run++;
        if (k != -1) begin
            n_fail++; $display("FAIL fill_stream: got diff@%0d required -1", k);
        end
        n_run++;
        if (done_cyc != 13 || cnt_at_done != 1) begin
            n_fail++; $display("FAIL fill_done: got cyc=%0d cnt=%0d required 13 1", done_cyc, cnt_at_done);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gap0();
        test_backpressure();
        test_repeat0();
        test_midrun_reset();
        test_lfsr_fill();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
